// File: rtl/spi_bus_arbiter.sv
// Arbitrates two byte requesters (OLED command sequencer, frame-buffer streamer)
// onto a single SpiMaster, with fixed cmd priority, per-owner lock and a done timeout.
module spi_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_dc,
  input  logic       cmd_lock,
  output logic       cmd_ack,
  input  logic       pix_req,
  input  logic [7:0] pix_byte,
  input  logic       pix_dc,
  input  logic       pix_lock,
  output logic       pix_ack,
  output logic       spi_start,
  output logic [7:0] spi_data,
  input  logic       spi_done,
  output logic       dc,
  output logic [1:0] owner,
  output logic       timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CMD  = 2'b01;
  localparam logic [1:0] OWN_PIX  = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             owner_req, owner_lock;
  logic             grant_cmd, grant_pix;
  logic             timeout_hit;

  assign owner_req  = (owner == OWN_PIX) ? pix_req  : cmd_req;
  assign owner_lock = (owner == OWN_PIX) ? pix_lock : cmd_lock;

  assign timeout_hit = (state == WAIT) && !spi_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Acks are Mealy outputs so a request seen in IDLE is acked in that same cycle;
  // gating with reset keeps them low while reset holds the FSM in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    grant_cmd = 1'b0;
    grant_pix = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cmd_req)      grant_cmd = 1'b1;
          else if (pix_req) grant_pix = 1'b1;
        end
        HOLD: begin
          grant_cmd = owner_req && (owner == OWN_CMD);
          grant_pix = owner_req && (owner == OWN_PIX);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ack   = grant_cmd;
  assign pix_ack   = grant_pix;
  assign spi_start = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_cmd || grant_pix) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (spi_done)         state_nxt = owner_lock ? HOLD : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      HOLD: begin
        if (owner_req)        state_nxt = ISSUE;
        else if (!owner_lock) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register, including the wait counter, has an explicit reset value; nothing powers up unknown.
    if (reset) begin
      state       <= IDLE;
      spi_data    <= 8'h00;
      dc          <= 1'b0;
      owner       <= OWN_NONE;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nxt;

      if (grant_cmd) begin
        spi_data <= cmd_byte;
        dc       <= cmd_dc;
        owner    <= OWN_CMD;
      end else if (grant_pix) begin
        spi_data <= pix_byte;
        dc       <= pix_dc;
        owner    <= OWN_PIX;
      end else if (state_nxt == IDLE) begin
        owner <= OWN_NONE;
      end

      if (timeout_hit) timeout_err <= 1'b1;

      // Cleared in ISSUE so it reads zero on the first WAIT cycle.
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: vector table for single grants, scoreboard
// on every spi_start, and directed sequences for contention, lock bursts, timeout and reset.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_req, cmd_dc, cmd_lock, cmd_ack;
  logic [7:0] cmd_byte;
  logic       pix_req, pix_dc, pix_lock, pix_ack;
  logic [7:0] pix_byte;
  logic       spi_start, spi_done, dc, timeout_err;
  logic [7:0] spi_data;
  logic [1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb_q[$];

  spi_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_req(cmd_req), .cmd_byte(cmd_byte), .cmd_dc(cmd_dc), .cmd_lock(cmd_lock), .cmd_ack(cmd_ack),
    .pix_req(pix_req), .pix_byte(pix_byte), .pix_dc(pix_dc), .pix_lock(pix_lock), .pix_ack(pix_ack),
    .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done),
    .dc(dc), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every spi_start must match the oldest accepted byte.
  always @(negedge clk) begin
    if (spi_start === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_spi_start", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check("sb_byte", {23'd0, dc, spi_data}, {23'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (spi_start === 1'b1) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  // From the ISSUE negedge: one WAIT cycle with done pulsed, returns at posedge+1 after done.
  task automatic finish_byte();
    step();
    @(negedge clk);
    check("wait_no_ack", {30'd0, cmd_ack, pix_ack}, 32'd0);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
  endtask

  typedef struct {
    logic       cmd_req, pix_req, cmd_dc, pix_dc;
    logic [7:0] cmd_byte, pix_byte;
    logic       exp_cmd_ack, exp_pix_ack;
    logic [1:0] exp_owner;
    logic [7:0] exp_byte;
    logic       exp_dc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 0, 0, 0, 8'hAE, 8'h00, 1, 0, 2'b01, 8'hAE, 0};
    vecs[1] = '{0, 1, 0, 1, 8'h00, 8'h5A, 0, 1, 2'b10, 8'h5A, 1};
    vecs[2] = '{1, 1, 1, 0, 8'h3C, 8'hC3, 1, 0, 2'b01, 8'h3C, 1};
    vecs[3] = '{0, 0, 1, 1, 8'h12, 8'h34, 0, 0, 2'b00, 8'h00, 0};
    vecs[4] = '{0, 1, 1, 0, 8'hFF, 8'h00, 0, 1, 2'b10, 8'h00, 0};
    vecs[5] = '{1, 1, 1, 1, 8'hFF, 8'h80, 1, 0, 2'b01, 8'hFF, 1};

    reset = 1'b1;
    {cmd_req, cmd_dc, cmd_lock, pix_req, pix_dc, pix_lock, spi_done} = '0;
    cmd_byte = 8'h00;
    pix_byte = 8'h00;
    #3;
    check("rst_outputs", {20'd0, spi_start, spi_data, dc, owner, timeout_err},
          {20'd0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0});
    step();
    reset = 1'b0;

    // Single grants from IDLE, including priority and no-request cases.
    for (int i = 0; i < 6; i++) begin
      step();
      cmd_req = vecs[i].cmd_req;  pix_req = vecs[i].pix_req;
      cmd_dc  = vecs[i].cmd_dc;   pix_dc  = vecs[i].pix_dc;
      cmd_byte = vecs[i].cmd_byte; pix_byte = vecs[i].pix_byte;
      if (vecs[i].exp_cmd_ack || vecs[i].exp_pix_ack)
        sb_q.push_back({vecs[i].exp_dc, vecs[i].exp_byte});
      @(negedge clk);
      check($sformatf("vec%0d_acks", i), {30'd0, cmd_ack, pix_ack},
            {30'd0, vecs[i].exp_cmd_ack, vecs[i].exp_pix_ack});
      step();
      cmd_req = 1'b0;
      pix_req = 1'b0;
      if (vecs[i].exp_cmd_ack || vecs[i].exp_pix_ack) begin
        wait_start($sformatf("vec%0d_start", i));
        check($sformatf("vec%0d_owner", i), {30'd0, owner}, {30'd0, vecs[i].exp_owner});
        finish_byte();
        @(negedge clk);
        check($sformatf("vec%0d_release", i), {30'd0, owner}, 32'd0);
        check($sformatf("vec%0d_hold_data", i), {23'd0, dc, spi_data},
              {23'd0, vecs[i].exp_dc, vecs[i].exp_byte});
      end else begin
        @(negedge clk);
        check($sformatf("vec%0d_idle", i), {29'd0, spi_start, owner}, 32'd0);
      end
    end

    // Contention: cmd first, pix acked in first IDLE cycle after cmd's done.
    step();
    cmd_req = 1'b1; cmd_byte = 8'hA1; cmd_dc = 1'b0;
    pix_req = 1'b1; pix_byte = 8'hB2; pix_dc = 1'b1;
    sb_q.push_back({1'b0, 8'hA1});
    @(negedge clk);
    check("cont_first", {30'd0, cmd_ack, pix_ack}, 32'b10);
    step();
    cmd_req = 1'b0;
    wait_start("cont_cmd_start");
    check("cont_pix_wait", {31'd0, pix_ack}, 32'd0);
    finish_byte();
    sb_q.push_back({1'b1, 8'hB2});
    @(negedge clk);
    check("cont_second", {30'd0, cmd_ack, pix_ack}, 32'b01);
    step();
    pix_req = 1'b0;
    wait_start("cont_pix_start");
    finish_byte();

    // Locked pix burst of 4 bytes while cmd_req stays high.
    pix_req = 1'b1; pix_byte = 8'h01; pix_dc = 1'b1; pix_lock = 1'b1;
    sb_q.push_back({1'b1, 8'h01});
    @(negedge clk);
    check("burst_ack1", {30'd0, cmd_ack, pix_ack}, 32'b01);
    step();
    pix_req = 1'b0;
    cmd_req = 1'b1; cmd_byte = 8'h99; cmd_dc = 1'b0;
    wait_start("burst_start1");
    finish_byte();
    for (int k = 2; k <= 4; k++) begin
      if (k == 3) begin
        @(negedge clk);
        check("burst_hold_idle", {28'd0, owner, cmd_ack, pix_ack}, {28'd0, 2'b10, 2'b00});
        step();
      end
      pix_byte = 8'(k);
      pix_req = 1'b1;
      if (k == 4) pix_lock = 1'b0;
      sb_q.push_back({1'b1, 8'(k)});
      @(negedge clk);
      check($sformatf("burst_ack%0d", k), {30'd0, cmd_ack, pix_ack}, 32'b01);
      step();
      pix_req = 1'b0;
      wait_start($sformatf("burst_start%0d", k));
      finish_byte();
    end
    sb_q.push_back({1'b0, 8'h99});
    @(negedge clk);
    check("burst_cmd_after", {30'd0, cmd_ack, pix_ack}, 32'b10);
    step();
    cmd_req = 1'b0;
    wait_start("burst_cmd_start");
    check("burst_cmd_owner", {30'd0, owner}, 32'b01);
    finish_byte();
    @(negedge clk);
    check("burst_cmd_release", {30'd0, owner}, 32'd0);

    // Timeout: spi_done never arrives.
    step();
    cmd_req = 1'b1; cmd_byte = 8'h11; cmd_dc = 1'b0;
    sb_q.push_back({1'b0, 8'h11});
    @(negedge clk);
    check("to_ack", {31'd0, cmd_ack}, 32'd1);
    step();
    cmd_req = 1'b0;
    wait_start("to_start");
    repeat (16) step();
    @(negedge clk);
    check("to_before", {29'd0, timeout_err, owner}, {29'd0, 1'b0, 2'b01});
    step();
    @(negedge clk);
    check("to_after", {29'd0, timeout_err, owner}, {29'd0, 1'b1, 2'b00});
    step();
    pix_req = 1'b1; pix_byte = 8'h22; pix_dc = 1'b0;
    sb_q.push_back({1'b0, 8'h22});
    @(negedge clk);
    check("to_next_ack", {31'd0, pix_ack}, 32'd1);
    step();
    pix_req = 1'b0;
    wait_start("to_next_start");
    finish_byte();
    @(negedge clk);
    check("to_sticky", {29'd0, timeout_err, owner}, {29'd0, 1'b1, 2'b00});

    // Asynchronous reset in WAIT with pix owning the bus.
    step();
    pix_req = 1'b1; pix_byte = 8'h77; pix_dc = 1'b1;
    sb_q.push_back({1'b1, 8'h77});
    @(negedge clk);
    check("rw_ack", {31'd0, pix_ack}, 32'd1);
    step();
    pix_req = 1'b0;
    wait_start("rw_start");
    step();
    #2;
    check("rw_owner", {30'd0, owner}, 32'b10);
    cmd_req = 1'b1;
    reset = 1'b1;
    #1;
    check("rw_async", {18'd0, spi_start, spi_data, dc, owner, timeout_err, cmd_ack, pix_ack}, 32'd0);
    repeat (2) step();
    @(negedge clk);
    check("rw_held", {28'd0, spi_start, owner, cmd_ack}, 32'd0);
    step();
    cmd_req = 1'b0;
    reset = 1'b0;
    spi_done = 1'b1;
    @(negedge clk);
    check("rw_stray_done", {28'd0, cmd_ack, pix_ack, spi_start, owner != 2'b00}, 32'd0);
    step();
    spi_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rw_quiet", {29'd0, spi_start, owner}, 32'd0);
    end
    step();
    cmd_req = 1'b1; cmd_byte = 8'h5C; cmd_dc = 1'b1;
    pix_req = 1'b1; pix_byte = 8'hA5; pix_dc = 1'b0;
    sb_q.push_back({1'b1, 8'h5C});
    @(negedge clk);
    check("rw_regrant", {30'd0, cmd_ack, pix_ack}, 32'b10);
    step();
    cmd_req = 1'b0;
    pix_req = 1'b0;
    wait_start("rw_regrant_start");
    finish_byte();
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of WAIT-state cycles allowed for spi_done before the transfer is abandoned.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port cmd_req  input  1  OLED init/config requester has a byte to send.
REQ-005 SHALL provide port cmd_byte  input  8  command requester byte.
REQ-006 SHALL provide port cmd_dc  input  1  D/C level for cmd_byte (0 = command, 1 = data).
REQ-007 SHALL provide port cmd_lock  input  1  command requester asks to keep the grant after the current byte.
REQ-008 SHALL provide port cmd_ack  output  1  one-cycle pulse; cmd_byte accepted.
REQ-009 SHALL provide ports pix_req, pix_byte[7:0], pix_dc, pix_lock (inputs) and pix_ack (output), with the same meanings for the frame-buffer streamer.
REQ-010 SHALL provide port spi_start  output  1  one-cycle start pulse to SpiMaster.
REQ-011 SHALL provide port spi_data  output  8  byte presented to SpiMaster.
REQ-012 SHALL provide port spi_done  input  1  one-cycle pulse from SpiMaster at byte completion.
REQ-013 SHALL provide port dc  output  1  OLED D/C pin level.
REQ-014 SHALL provide port owner  output  2  current grant: 00 none, 01 cmd, 10 pix.
REQ-015 SHALL provide port timeout_err  output  1  sticky flag; spi_done not received in time.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, HOLD.
REQ-017 In IDLE with cmd_req high, the block SHALL grant cmd, latch cmd_byte/cmd_dc into spi_data/dc, pulse cmd_ack in that cycle, set owner=01, and go to ISSUE.
REQ-018 In IDLE with only pix_req high, the block SHALL do the same for pix (owner=10, pix_ack).
REQ-019 When both requests are high in IDLE, cmd SHALL win (fixed priority).
REQ-020 ISSUE SHALL last exactly one cycle with spi_start=1, then go to WAIT; spi_start SHALL be 0 in every other state.
REQ-021 Latency: a request sampled in IDLE at cycle N SHALL produce ack at N and spi_start at N+1.
REQ-022 In WAIT, on spi_done: if the owner's lock is high go to HOLD, else go to IDLE with owner=00.
REQ-023 In HOLD, the owner SHALL keep the grant; the other requester SHALL NOT be acked, even if it has priority.
REQ-024 In HOLD, an owner req SHALL be latched and acked and the FSM SHALL go to ISSUE; if owner lock is low and owner req is low, the FSM SHALL go to IDLE with owner=00 that cycle.
REQ-025 In HOLD, when owner req is high and lock is low in the same cycle, the byte SHALL be sent (req wins) and the grant SHALL release after its spi_done.
REQ-026 A 10-bit-or-wider WAIT counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYCLES without spi_done, timeout_err SHALL set, owner SHALL become 00, and the FSM SHALL go to IDLE.
REQ-027 spi_done SHALL be ignored outside WAIT.
REQ-028 spi_data and dc SHALL hold their last latched values until the next acceptance.
REQ-029 At most one ack SHALL be high in any cycle, and acks SHALL occur only in IDLE or HOLD.

Reset
REQ-030 While reset is high, regardless of clk: state=IDLE, spi_start=0, spi_data=8'h00, dc=0, owner=00, cmd_ack=0, pix_ack=0, timeout_err=0, WAIT counter=0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately with no further spi_start; the first grant after reset release SHALL follow REQ-017 to REQ-019.
REQ-032 timeout_err SHALL clear only by reset.

Verification
REQ-033 Single cmd: cmd_req=1, cmd_byte=8'hAE, cmd_dc=0, lock=0 -> cmd_ack at N, spi_start at N+1, spi_data=AE, dc=0; after spi_done, owner=00.
REQ-034 Contention: cmd_req and pix_req both high in IDLE -> cmd acked first; pix acked in the first IDLE cycle after cmd's spi_done.
REQ-035 Burst lock: pix_lock=1 with 4 bytes 01,02,03,04 while cmd_req is high throughout -> all 4 pix bytes sent back-to-back, no cmd_ack until pix_lock drops, then cmd granted.
REQ-036 Timeout: TIMEOUT_CYCLES=16, spi_done never pulses -> timeout_err=1 sixteen cycles after WAIT entry, owner=00, next request still served.
REQ-037 Reset during WAIT with owner=10 -> all outputs at REQ-030 values asynchronously; a stray spi_done afterwards causes no ack and no spi_start.
